// File: rtl/mdr_cmd_seq_pkg.sv
// -----------------------------------------------------------------------------
// mdr_cmd_seq_pkg
// Shared types and defaults for the MDR command sequencer.
//   op_e      : command / MDR opcode encoding
//   state_e   : sequencer FSM states
//   cnt_width : width needed for a down-counter that starts at max_val
// -----------------------------------------------------------------------------
package mdr_cmd_seq_pkg;

  localparam int DW_DEFAULT      = 16;
  localparam int TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_LOAD_Y = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Counter width able to hold max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/mdr_timeout_cnt.sv
// -----------------------------------------------------------------------------
// mdr_timeout_cnt
// Down-counter guarding the wait for MDR completion.
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-low reset (count cleared to 0)
//   i_load    in  load TIMEOUT (takes priority over i_en)
//   i_en      in  decrement by one while non-zero
//   o_expired out count has reached 0
// -----------------------------------------------------------------------------
module mdr_timeout_cnt
  import mdr_cmd_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Load on WAIT entry, then count down and saturate at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mdr_cmd_seq.sv
// -----------------------------------------------------------------------------
// mdr_cmd_seq
// Sequences one mul/div/sqrt command through a multi-cycle MDR unit:
// start pulse, operand loads on MDR request, bounded wait for completion,
// then a held response until consumed.
//   clk, rst                       clock / async active-low reset
//   cmd_valid/ready/op/x/y         command handshake and operands
//   mdr_data/op/load/start         operand, opcode and pulses to the MDR
//   mdr_load_x/load_y              MDR operand requests
//   mdr_ready/error/result/remainder  MDR completion and outputs
//   rsp_valid/ready/result/remainder/error/timeout  response handshake
//   busy                           high whenever not IDLE
// -----------------------------------------------------------------------------
module mdr_cmd_seq
  import mdr_cmd_seq_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_x,
  input  logic [DW-1:0] cmd_y,
  output logic [DW-1:0] mdr_data,
  output logic [1:0]    mdr_op,
  output logic          mdr_load,
  output logic          mdr_start,
  input  logic          mdr_load_x,
  input  logic          mdr_load_y,
  input  logic          mdr_ready,
  input  logic          mdr_error,
  input  logic [DW-1:0] mdr_result,
  input  logic [DW-1:0] mdr_remainder,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic [DW-1:0] rsp_remainder,
  output logic          rsp_error,
  output logic          rsp_timeout,
  output logic          busy
);

  state_e        r_state;
  op_e           r_op;
  logic [DW-1:0] r_x;
  logic [DW-1:0] r_y;
  logic          r_mdr_start;
  logic [1:0]    r_mdr_op;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_result;
  logic [DW-1:0] r_rsp_remainder;
  logic          r_rsp_error;
  logic          r_rsp_timeout;
  logic          r_busy;

  logic          w_load_x_hit;
  logic          w_load_y_hit;
  logic          w_enter_wait;
  logic          w_in_wait;
  logic          w_expired;

  // The MDR samples the operand in the same cycle it raises its request,
  // so the load pulse is decoded directly from state and request.
  assign w_load_x_hit = (r_state == ST_LOAD_X) && mdr_load_x;
  assign w_load_y_hit = (r_state == ST_LOAD_Y) && mdr_load_y;
  assign w_enter_wait = (w_load_x_hit && (r_op == OP_SQRT)) || w_load_y_hit;
  assign w_in_wait    = (r_state == ST_WAIT);

  mdr_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_enter_wait),
    .i_en      (w_in_wait),
    .o_expired (w_expired)
  );

  // Operand mux towards the MDR; bus is quiet unless a load is pulsed.
  always_comb begin
    mdr_load = 1'b0;
    mdr_data = '0;
    if (w_load_x_hit) begin
      mdr_load = 1'b1;
      mdr_data = r_x;
    end else if (w_load_y_hit) begin
      mdr_load = 1'b1;
      mdr_data = r_y;
    end else begin
      mdr_load = 1'b0;
      mdr_data = '0;
    end
  end

  // Sequencer FSM with registered MDR control and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_op            <= OP_MUL;
      r_x             <= '0;
      r_y             <= '0;
      r_mdr_start     <= 1'b0;
      r_mdr_op        <= 2'b00;
      r_rsp_valid     <= 1'b0;
      r_rsp_result    <= '0;
      r_rsp_remainder <= '0;
      r_rsp_error     <= 1'b0;
      r_rsp_timeout   <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op   <= op_e'(cmd_op);
            r_x    <= cmd_x;
            r_y    <= cmd_y;
            r_busy <= 1'b1;
            if (cmd_op == OP_ILL) begin
              // Illegal opcode never touches the MDR.
              r_state         <= ST_RESP;
              r_rsp_valid     <= 1'b1;
              r_rsp_result    <= '0;
              r_rsp_remainder <= '0;
              r_rsp_error     <= 1'b1;
              r_rsp_timeout   <= 1'b0;
            end else begin
              r_state     <= ST_START;
              r_mdr_start <= 1'b1;
              r_mdr_op    <= cmd_op;
            end
          end
        end
        ST_START: begin
          r_mdr_start <= 1'b0;
          r_state     <= ST_LOAD_X;
        end
        ST_LOAD_X: begin
          if (mdr_load_x) begin
            r_state <= (r_op == OP_SQRT) ? ST_WAIT : ST_LOAD_Y;
          end
        end
        ST_LOAD_Y: begin
          if (mdr_load_y) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Completion takes precedence over a counter that hits zero
          // in the same cycle; mdr_error dominates mdr_ready.
          if (mdr_ready || mdr_error) begin
            r_state         <= ST_RESP;
            r_mdr_op        <= 2'b00;
            r_rsp_valid     <= 1'b1;
            r_rsp_result    <= mdr_result;
            r_rsp_remainder <= mdr_remainder;
            r_rsp_error     <= mdr_error;
            r_rsp_timeout   <= 1'b0;
          end else if (w_expired) begin
            r_state         <= ST_RESP;
            r_mdr_op        <= 2'b00;
            r_rsp_valid     <= 1'b1;
            r_rsp_result    <= '0;
            r_rsp_remainder <= '0;
            r_rsp_error     <= 1'b1;
            r_rsp_timeout   <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_result    <= '0;
            r_rsp_remainder <= '0;
            r_rsp_error     <= 1'b0;
            r_rsp_timeout   <= 1'b0;
          end
        end
        default: begin
          r_state         <= ST_IDLE;
          r_mdr_start     <= 1'b0;
          r_mdr_op        <= 2'b00;
          r_rsp_valid     <= 1'b0;
          r_rsp_result    <= '0;
          r_rsp_remainder <= '0;
          r_rsp_error     <= 1'b0;
          r_rsp_timeout   <= 1'b0;
          r_busy          <= 1'b0;
        end
      endcase
    end
  end

  // Ready only from IDLE, which also yields the one-cycle bubble after RESP.
  assign cmd_ready     = (r_state == ST_IDLE);
  assign mdr_start     = r_mdr_start;
  assign mdr_op        = r_mdr_op;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_remainder = r_rsp_remainder;
  assign rsp_error     = r_rsp_error;
  assign rsp_timeout   = r_rsp_timeout;
  assign busy          = r_busy;

endmodule

// File: tb/tb_mdr_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_mdr_cmd_seq
// Directed bench: the initial block plays both the command master and the
// MDR unit. Expected responses are queued when a command is issued and
// popped when the response appears.
// -----------------------------------------------------------------------------
module tb_mdr_cmd_seq;
  import mdr_cmd_seq_pkg::*;

  localparam int DW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_x = '0;
  logic [DW-1:0] cmd_y = '0;
  logic [DW-1:0] mdr_data;
  logic [1:0]    mdr_op;
  logic          mdr_load;
  logic          mdr_start;
  logic          mdr_load_x = 1'b0;
  logic          mdr_load_y = 1'b0;
  logic          mdr_ready = 1'b0;
  logic          mdr_error = 1'b0;
  logic [DW-1:0] mdr_result = '0;
  logic [DW-1:0] mdr_remainder = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic [DW-1:0] rsp_remainder;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          busy;

  mdr_cmd_seq #(.DW(DW), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .mdr_data      (mdr_data),
    .mdr_op        (mdr_op),
    .mdr_load      (mdr_load),
    .mdr_start     (mdr_start),
    .mdr_load_x    (mdr_load_x),
    .mdr_load_y    (mdr_load_y),
    .mdr_ready     (mdr_ready),
    .mdr_error     (mdr_error),
    .mdr_result    (mdr_result),
    .mdr_remainder (mdr_remainder),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_remainder (rsp_remainder),
    .rsp_error     (rsp_error),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [DW-1:0] rem;
    logic          err;
    logic          to;
  } rsp_t;

  rsp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            start_cnt = 0;
  int            load_cnt = 0;
  logic [DW-1:0] cap_x = '0;
  logic [DW-1:0] cap_y = '0;

  // Count MDR pulses as the MDR would see them on the clock edge.
  always @(posedge clk) begin
    if (mdr_start) start_cnt <= start_cnt + 1;
    if (mdr_load)  load_cnt  <= load_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic of the MDR unit (mul returns high half as remainder).
  function automatic void model(input logic [1:0] op, input logic [DW-1:0] a,
                                input logic [DW-1:0] b,
                                output logic [DW-1:0] r, output logic [DW-1:0] m);
    logic [31:0] p;
    r = '0;
    m = '0;
    case (op)
      2'b00: begin
        p = 32'(a) * 32'(b);
        r = p[15:0];
        m = p[31:16];
      end
      2'b01: begin
        if (b != 16'd0) begin
          r = a / b;
          m = a % b;
        end
      end
      2'b10: begin
        for (int i = 0; i < 256; i++) begin
          if (i * i <= int'(a)) r = 16'(i);
        end
        m = a - 16'(r * r);
      end
      default: begin
        r = '0;
        m = '0;
      end
    endcase
  endfunction

  // mode: 0 normal, 1 MDR error with ready, 2 MDR never completes, 3 aborted
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] x,
                       input logic [DW-1:0] y, input int mode);
    int            s0;
    int            l0;
    int            n;
    logic [DW-1:0] r;
    logic [DW-1:0] m;
    rsp_t          e;
    s0 = start_cnt;
    l0 = load_cnt;
    model(op, x, y, r, m);
    e = '{res: r, rem: m, err: 1'b0, to: 1'b0};
    if (op == 2'b11)   e = '{res: 16'h0, rem: 16'h0, err: 1'b1, to: 1'b0};
    else if (mode == 1) e = '{res: 16'hDEAD, rem: 16'hBEEF, err: 1'b1, to: 1'b0};
    else if (mode == 2) e = '{res: 16'h0, rem: 16'h0, err: 1'b1, to: 1'b1};
    if (mode != 3) sb.push_back(e);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_x     = '0;
    cmd_y     = '0;
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", cmd_ready, 0);

    if (op == 2'b11) begin
      chk("ill_no_start", mdr_start, 0);
      chk("ill_no_op", mdr_op, 0);
      chk("ill_start_cnt", start_cnt - s0, 0);
      chk("ill_load_cnt", load_cnt - l0, 0);
    end else begin
      chk("start_pulse", mdr_start, 1);
      chk("start_op", mdr_op, op);
      tick();
      chk("start_once", mdr_start, 0);
      chk("op_hold_load", mdr_op, op);
      chk("load_quiet", mdr_load, 0);
      chk("data_quiet", mdr_data, 0);
      // Completion strobes outside WAIT must be ignored.
      mdr_ready  = 1'b1;
      mdr_error  = 1'b1;
      mdr_result = 16'h5555;
      tick();
      mdr_ready  = 1'b0;
      mdr_error  = 1'b0;
      mdr_result = '0;
      chk("early_done_ignored", rsp_valid, 0);
      mdr_load_x = 1'b1;
      #1;
      chk("load_x_pulse", mdr_load, 1);
      chk("load_x_data", mdr_data, x);
      cap_x = mdr_data;
      tick();
      mdr_load_x = 1'b0;
      if (op != 2'b10) begin
        chk("load_y_wait", mdr_load, 0);
        mdr_load_y = 1'b1;
        #1;
        chk("load_y_pulse", mdr_load, 1);
        chk("load_y_data", mdr_data, y);
        cap_y = mdr_data;
        tick();
        mdr_load_y = 1'b0;
      end else begin
        // Already in WAIT: a Y request must not produce a load.
        mdr_load_y = 1'b1;
        #1;
        chk("sqrt_skip_y", mdr_load, 0);
        mdr_load_y = 1'b0;
        cap_y = '0;
      end
      chk("op_hold_wait", mdr_op, op);
      chk("start_count", start_cnt - s0, 1);
      chk("load_count", load_cnt - l0, (op == 2'b10) ? 1 : 2);
    end
  endtask

  task automatic complete(input logic [1:0] op, input int mode);
    logic [DW-1:0] r;
    logic [DW-1:0] m;
    int            n;
    if (mode == 0) begin
      model(op, cap_x, cap_y, r, m);
      mdr_result    = r;
      mdr_remainder = m;
      mdr_ready     = 1'b1;
      tick();
    end else if (mode == 1) begin
      mdr_result    = 16'hDEAD;
      mdr_remainder = 16'hBEEF;
      mdr_ready     = 1'b1;
      mdr_error     = 1'b1;
      tick();
    end else begin
      mdr_result    = 16'h1234;
      mdr_remainder = 16'h5678;
      n = 0;
      while (!rsp_valid && n < 30) begin
        tick();
        n++;
      end
      chk("timeout_latency", n, TMO + 1);
    end
    mdr_ready     = 1'b0;
    mdr_error     = 1'b0;
    mdr_result    = '0;
    mdr_remainder = '0;
  endtask

  task automatic drain(input int hold);
    rsp_t e;
    int   n;
    e = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid_held", rsp_valid, 1);
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_remainder", rsp_remainder, e.rem);
      chk("rsp_error", rsp_error, e.err);
      chk("rsp_timeout", rsp_timeout, e.to);
      chk("op_idle_resp", mdr_op, 0);
      if (i < hold) tick();
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("bubble_no_ready", cmd_ready, 0);
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("rsp_dropped", rsp_valid, 0);
    chk("busy_cleared", busy, 0);
    chk("ready_again", cmd_ready, 1);
  endtask

  initial begin
    int s;
    int l;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mdr_start", mdr_start, 0);
    chk("rst_mdr_op", mdr_op, 0);
    chk("rst_rsp_error", rsp_error, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    tick();

    issue(2'b00, 16'd7, 16'd6, 0);     complete(2'b00, 0); drain(0);
    issue(2'b01, 16'd100, 16'd7, 0);   complete(2'b01, 0); drain(5);
    issue(2'b10, 16'd81, 16'd0, 0);    complete(2'b10, 0); drain(0);
    issue(2'b00, 16'hFFFF, 16'd3, 0);  complete(2'b00, 0); drain(0);
    issue(2'b01, 16'd50, 16'd0, 1);    complete(2'b01, 1); drain(0);
    issue(2'b11, 16'd3, 16'd4, 0);     drain(1);
    issue(2'b00, 16'd9, 16'd9, 2);     complete(2'b00, 2); drain(0);

    // Reset while waiting for the MDR: command is abandoned.
    issue(2'b00, 16'd5, 16'd5, 3);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_mdr_op", mdr_op, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    s = start_cnt;
    l = load_cnt;
    mdr_ready  = 1'b1;
    mdr_result = 16'd77;
    repeat (3) tick();
    mdr_ready  = 1'b0;
    mdr_result = '0;
    chk("abort_no_rsp", rsp_valid, 0);
    chk("abort_no_start", start_cnt - s, 0);
    chk("abort_no_load", load_cnt - l, 0);

    issue(2'b00, 16'd123, 16'd45, 0);  complete(2'b00, 0); drain(0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mdr_cmd_seq.md
MDR_CMD_SEQ -- requirements
Module: mdr_cmd_seq

Interface
REQ-001 Parameter DW, default 16, data width of operands and results.
REQ-002 Parameter TIMEOUT, default 1023, max cycles waited for MDR completion.
REQ-003 clk  in  1  single clock for all state; rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  in  2  00 mul, 01 div, 10 sqrt, 11 illegal.
REQ-008 cmd_x, cmd_y  in  DW  operands; cmd_y is ignored for sqrt.
REQ-009 mdr_data  out  DW  operand to MDR.
REQ-010 mdr_op  out  2  opcode to MDR.
REQ-011 mdr_load, mdr_start  out  1  one-cycle pulses to MDR.
REQ-012 mdr_load_x, mdr_load_y  in  1  MDR requests X or Y operand.
REQ-013 mdr_ready, mdr_error  in  1  MDR done and MDR fault.
REQ-014 mdr_result, mdr_remainder  in  DW  MDR outputs.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-017 rsp_result, rsp_remainder  out  DW  captured results.
REQ-018 rsp_error, rsp_timeout  out  1  error flags for the response.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, START, LOAD_X, LOAD_Y, WAIT, RESP.
REQ-021 cmd_ready SHALL equal (state==IDLE); on accept, op, x and y are registered.
REQ-022 On accept with op 11, the block SHALL go directly to RESP with rsp_error=1, results 0, and SHALL NOT pulse any MDR output.
REQ-023 START: mdr_start=1 and mdr_op=op for exactly one cycle, then LOAD_X.
REQ-024 LOAD_X: wait for mdr_load_x=1; in that cycle mdr_data=x and mdr_load=1 for one cycle; then LOAD_Y for mul/div, or WAIT for sqrt.
REQ-025 LOAD_Y: wait for mdr_load_y=1; pulse mdr_load with mdr_data=y for one cycle; then WAIT.
REQ-026 mdr_op SHALL hold the registered op from START through WAIT; mdr_data is 0 whenever mdr_load=0.
REQ-027 WAIT: a down-counter loads TIMEOUT on entry and decrements each cycle.
REQ-028 In WAIT, on mdr_ready or mdr_error, the block SHALL capture mdr_result, mdr_remainder and mdr_error, then go to RESP.
REQ-029 If mdr_ready and mdr_error rise in the same cycle, mdr_error wins: rsp_error=1, results still captured.
REQ-030 If the counter reaches 0 before completion: rsp_timeout=1, rsp_error=1, results 0, then RESP.
REQ-031 mdr_ready or mdr_error asserted outside WAIT SHALL be ignored.
REQ-032 RESP: rsp_valid=1 with stable payload until rsp_ready=1, then IDLE on the next edge; latency from accept to rsp_valid is at least 4 cycles.
REQ-033 No new command SHALL be accepted in the handshake cycle that leaves RESP (one idle bubble).

Reset
REQ-034 rst low SHALL force IDLE immediately, without waiting for a clock edge.
REQ-035 During and after reset: cmd_ready=1 once rst is high; all other outputs 0, counter 0, registered operands 0.
REQ-036 Reset mid-operation SHALL abandon the command with no response and no further MDR pulses.

Structure
REQ-037 A shared package SHALL hold the opcode enum (OP_MUL, OP_DIV, OP_SQRT, OP_ILL), the state enum, DW_DEFAULT and TIMEOUT_DEFAULT.
REQ-038 The WAIT timeout counter SHALL be a sub-module mdr_timeout_cnt (load, enable, expired).

Verification
REQ-039 mul x=7, y=6, MDR returns 42 -> one start pulse, two load pulses (7 then 6), rsp_result=42, rsp_error=0.
REQ-040 div x=100, y=7 -> rsp_result=14, rsp_remainder=2; hold rsp_ready low 5 cycles -> payload stable, rsp_valid held.
REQ-041 sqrt x=81 -> exactly one load pulse, LOAD_Y skipped, rsp_result=9.
REQ-042 div y=0 with MDR asserting mdr_error together with mdr_ready -> rsp_error=1; op 11 -> rsp_error=1, zero MDR pulses.
REQ-043 TIMEOUT=8 with MDR never ready -> rsp_timeout=1 nine cycles after WAIT entry.
REQ-044 rst low during WAIT -> busy=0 and rsp_valid=0 immediately; next command completes normally.
